mm_addr_sequencer: RTL

Parametrised address sequencer for the matrix-multiplication cores. It replaces the fixed CI/CJ/CK and SI/SJ/SK counter set with a configurable i/j/k loop nest. It generates one (A, B, D) data-memory address triple per multiply-accumulate step and hands it to the core datapath over a valid/ready stream. Rows are interleaved across NCORES cores: each instance owns rows CORE_ID, CORE_ID+NCORES, and so on. Dimensions and base addresses are loaded at start rather than fixed.

---
 rtl/mm_addr_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mm_addr_sequencer.sv
// Configurable i/j/k loop-nest address sequencer for the matrix-multiply cores.
// Emits one (A, B, D) address triple per MAC step over a valid/ready stream; rows are interleaved across NCORES.
module mm_addr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DIM_W   = 4,
  parameter int NCORES  = 3,
  parameter int CORE_ID = 0
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  p_dim,
  input  logic [DIM_W-1:0]  q_dim,
  input  logic [DIM_W-1:0]  r_dim,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              k_first,
  output logic              k_last
);

  localparam int IW = DIM_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [DIM_W-1:0]  p_reg, q_reg, r_reg;
  logic [ADDR_W-1:0] base_a_reg, base_b_reg, base_d_reg;
  logic [ADDR_W-1:0] step_a_reg, step_d_reg, row_a_reg, row_d_reg;
  logic [ADDR_W-1:0] addr_a_reg, addr_b_reg, addr_d_reg;
  logic [IW-1:0]     i_reg;
  logic [DIM_W-1:0]  j_reg, k_reg;

  logic [DIM_W-1:0]  q_last, r_last;
  logic [ADDR_W-1:0] step_a_init, step_d_init, row_a_init, row_d_init;
  logic              degenerate, k_end, j_end, more_rows, last_beat, fire;

  assign q_last = q_reg - DIM_W'(1);
  assign r_last = r_reg - DIM_W'(1);

  // Loop-invariant products derived from the latched dimensions, used only in LOAD.
  assign step_a_init = ADDR_W'(NCORES * int'(q_reg));
  assign step_d_init = ADDR_W'(NCORES * int'(r_reg));
  assign row_a_init  = base_a_reg + ADDR_W'(CORE_ID * int'(q_reg));
  assign row_d_init  = base_d_reg + ADDR_W'(CORE_ID * int'(r_reg));

  assign degenerate = (p_reg == '0) || (q_reg == '0) || (r_reg == '0) ||
                      (CORE_ID >= int'(p_reg));

  assign k_end     = (k_reg == q_last);
  assign j_end     = (j_reg == r_last);
  // Compare in int so the row step can never wrap the comparison.
  assign more_rows = (int'(i_reg) + NCORES) < int'(p_reg);
  assign last_beat = k_end && j_end && !more_rows;
  assign fire      = (state_reg == RUN) && out_ready;

  always_ff @(posedge clock) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = degenerate ? DONE : RUN;
      RUN:     if (fire && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    out_valid = (state_reg == RUN);
    k_first   = (state_reg == RUN) && (k_reg == '0);
    k_last    = (state_reg == RUN) && k_end;
    addr_a    = addr_a_reg;
    addr_b    = addr_b_reg;
    addr_d    = addr_d_reg;
  end

  always_ff @(posedge clock) begin
    if (RST) begin
      p_reg      <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      base_a_reg <= '0;
      base_b_reg <= '0;
      base_d_reg <= '0;
      step_a_reg <= '0;
      step_d_reg <= '0;
      row_a_reg  <= '0;
      row_d_reg  <= '0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      addr_d_reg <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            p_reg      <= p_dim;
            q_reg      <= q_dim;
            r_reg      <= r_dim;
            base_a_reg <= base_a;
            base_b_reg <= base_b;
            base_d_reg <= base_d;
          end
        end
        LOAD: begin
          step_a_reg <= step_a_init;
          step_d_reg <= step_d_init;
          row_a_reg  <= row_a_init;
          row_d_reg  <= row_d_init;
          addr_a_reg <= row_a_init;
          addr_b_reg <= base_b_reg;
          addr_d_reg <= row_d_init;
          i_reg      <= IW'(CORE_ID);
          j_reg      <= '0;
          k_reg      <= '0;
        end
        RUN: begin
          if (out_ready) begin
            if (!k_end) begin
              k_reg      <= k_reg + DIM_W'(1);
              addr_a_reg <= addr_a_reg + ADDR_W'(1);
              addr_b_reg <= addr_b_reg + ADDR_W'(r_reg);
            end else if (!j_end) begin
              k_reg      <= '0;
              j_reg      <= j_reg + DIM_W'(1);
              addr_a_reg <= row_a_reg;
              addr_b_reg <= base_b_reg + ADDR_W'(j_reg) + ADDR_W'(1);
              addr_d_reg <= addr_d_reg + ADDR_W'(1);
            end else if (more_rows) begin
              i_reg      <= i_reg + IW'(NCORES);
              j_reg      <= '0;
              k_reg      <= '0;
              row_a_reg  <= row_a_reg + step_a_reg;
              row_d_reg  <= row_d_reg + step_d_reg;
              addr_a_reg <= row_a_reg + step_a_reg;
              addr_b_reg <= base_b_reg;
              addr_d_reg <= row_d_reg + step_d_reg;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
